// File: rtl/irq_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// irq is a registered output derived from next-state values, so it has no bus-to-output combinational path.
module irq_timer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t                 state;
    logic                   en;
    logic                   im;
    logic [1:0]             mode;
    logic [CNT_WIDTH-1:0]   preset;
    logic [CNT_WIDTH-1:0]   count;
    logic                   irq_flag;

    logic                   wr_ctrl;
    logic                   wr_preset;
    logic                   auto_reload;
    logic                   cnt_done;
    logic                   en_next;
    logic                   im_next;
    logic [1:0]             mode_next;
    logic                   flag_next;

    logic                   unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        wr_ctrl     = we && (addr[3:2] == 2'd0);
        wr_preset   = we && (addr[3:2] == 2'd1);
        auto_reload = (mode == 2'd1);
        cnt_done    = (state == CNT) && en && (count <= CNT_WIDTH'(1));

        en_next   = en;
        mode_next = mode;
        im_next   = im;
        if (wr_ctrl) begin
            en_next   = wdata[0];
            mode_next = wdata[2:1];
            im_next   = wdata[3];
        end else if ((state == INT) && !auto_reload) begin
            en_next = 1'b0;
        end

        // A CTRL write acknowledges only when IM stays set; masking or unmasking keeps the flag.
        flag_next = irq_flag;
        if (cnt_done) begin
            flag_next = 1'b1;
        end else if ((state == INT) && auto_reload) begin
            flag_next = 1'b0;
        end else if (wr_preset || (wr_ctrl && im && wdata[3])) begin
            flag_next = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0:    rdata = {28'd0, im, mode, en};
            2'd1:    rdata = 32'(preset);
            2'd2:    rdata = 32'(count);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            im       <= 1'b0;
            mode     <= 2'd0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            en       <= en_next;
            mode     <= mode_next;
            im       <= im_next;
            irq_flag <= flag_next;
            irq      <= flag_next & im_next;
            if (wr_preset) begin
                preset <= wdata[CNT_WIDTH-1:0];
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count <= CNT_WIDTH'(1)) begin
                        count <= '0;
                        state <= INT;
                    end else begin
                        count <= count - CNT_WIDTH'(1);
                    end
                end
                INT: begin
                    state <= auto_reload ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_timer.sv
// Scoreboard bench for irq_timer: the driver queues per-cycle expectations from an arithmetic
// timeline model; a negedge monitor pops and compares them against rdata and irq.
module tb_irq_timer;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    irq_timer #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          cr;
        logic [31:0] er;
        bit          ci;
        bit          ei;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp_v);
        end
    endfunction

    // Timeline of a run whose enabling CTRL write lands at edge E0; k counts edges after E0.
    function automatic void model(input int p, input logic [31:0] ctrlv, input int k,
                                  output bit cv, output logic [31:0] cnt, output bit ie);
        int pe;
        int per;
        int j;
        int ph;
        bit im;
        pe  = (p < 1) ? 1 : p;
        per = pe + 2;
        im  = ctrlv[3];
        cv  = 1'b0;
        cnt = '0;
        ie  = 1'b0;
        if (k >= 2) begin
            j  = k - 2;
            cv = 1'b1;
            if (ctrlv[2:1] == 2'd1) begin
                ph  = j % per;
                cnt = (p - ph > 0) ? 32'(p - ph) : 32'd0;
                ie  = im && (ph == pe);
            end else begin
                cnt = (p - j > 0) ? 32'(p - j) : 32'd0;
                ie  = im && (j >= pe);
            end
        end
    endfunction

    task automatic cyc(input logic [31:0] a, input bit w, input logic [31:0] d,
                       input bit cr, input logic [31:0] er, input bit ci, input bit ei,
                       input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        addr  = a;
        we    = w;
        wdata = d;
        e.tag = tag;
        e.cr  = cr;
        e.er  = er;
        e.ci  = ci;
        e.ei  = ei;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] er, input bit ei, input string tag);
        cyc(a, 1'b0, 32'd0, 1'b1, er, 1'b1, ei, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(a, 1'b1, d, 1'b0, 32'd0, 1'b0, 1'b0, "wr");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'h8, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "idle");
    endtask

    task automatic obs(input int p, input logic [31:0] ctrlv, input int k0, input int k1, input string tag);
        bit          cv;
        logic [31:0] cnt;
        bit          ie;
        for (int k = k0; k < k1; k++) begin
            model(p, ctrlv, k, cv, cnt, ie);
            cyc(32'h8, 1'b0, 32'd0, cv, cnt, 1'b1, ie, $sformatf("%s_k%0d", tag, k));
        end
    endtask

    task automatic run_timer(input int p, input logic [31:0] ctrlv, input int n, input string tag);
        wr(32'h4, 32'(p));
        wr(32'h0, ctrlv);
        obs(p, ctrlv, 0, n, tag);
    endtask

    task automatic stop_settle();
        wr(32'h0, 32'h0);
        idle(8);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cr) chk({e.tag, "_rdata"}, rdata, e.er);
                if (e.ci) chk({e.tag, "_irq"}, {31'd0, irq}, {31'd0, e.ei});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p;
        int          n;
        int          pe;
        logic [31:0] ctrlv;

        reset = 1'b0;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;

        rd(32'h0, 32'h0, 1'b0, "rst_ctrl");
        rd(32'h4, 32'h0, 1'b0, "rst_preset");
        rd(32'h8, 32'h0, 1'b0, "rst_count");
        rd(32'hC, 32'h0, 1'b0, "rst_resv");
        reset = 1'b1;
        rd(32'h0, 32'h0, 1'b0, "post_rst_ctrl");

        // Asynchronous reset in the middle of a countdown at COUNT=7
        run_timer(10, 32'h9, 6, "pre_rst");
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_count", rdata, 32'h0);
        chk("async_irq", {31'd0, irq}, 32'h0);
        addr = 32'h0;
        #1;
        chk("async_ctrl", rdata, 32'h0);
        rd(32'h4, 32'h0, 1'b0, "async_preset");
        rd(32'hC, 32'h0, 1'b0, "async_resv");
        reset = 1'b1;
        for (int i = 0; i < 12; i++) rd(32'h8, 32'h0, 1'b0, "no_irq_after_rst");
        rd(32'h0, 32'h0, 1'b0, "ctrl_after_rst");

        // One-shot, PRESET=5
        run_timer(5, 32'h9, 8, "oneshot");
        rd(32'h0, 32'h8, 1'b1, "oneshot_ctrl_en_clr");
        cyc(32'h0, 1'b1, 32'h8, 1'b1, 32'h8, 1'b1, 1'b1, "oneshot_ack_wr");
        rd(32'h0, 32'h8, 1'b0, "oneshot_ack");
        rd(32'h0, 32'h8, 1'b0, "oneshot_ack_hold");

        // Auto-reload, PRESET=3
        run_timer(3, 32'hB, 17, "auto");
        stop_settle();

        // Masked one-shot, then unmask exposes the retained flag
        run_timer(4, 32'h1, 10, "masked");
        rd(32'h0, 32'h0, 1'b0, "masked_ctrl");
        cyc(32'h0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b1, 1'b0, "unmask_wr");
        rd(32'h0, 32'h8, 1'b1, "unmask_irq");
        rd(32'h0, 32'h8, 1'b1, "unmask_irq_hold");

        // EN cleared so that COUNT freezes at 4
        wr(32'h4, 32'd8);
        wr(32'h0, 32'h9);
        obs(8, 32'h9, 0, 5, "stop");
        cyc(32'h0, 1'b1, 32'h8, 1'b1, 32'h9, 1'b1, 1'b0, "stop_wr");
        for (int i = 0; i < 10; i++) rd(32'h8, 32'd4, 1'b0, "stop_frozen");

        // Writes to COUNT and the reserved slot are ignored
        wr(32'h8, 32'h0000_FFFF);
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'h8, 32'd4, 1'b0, "count_ro");
        rd(32'hC, 32'h0, 1'b0, "resv_zero");
        rd(32'h0, 32'h8, 1'b0, "resv_no_ctrl");
        rd(32'h4, 32'd8, 1'b0, "resv_no_preset");

        // PRESET=0 and PRESET=1 share timing
        run_timer(0, 32'h9, 7, "preset0");
        run_timer(1, 32'h9, 7, "preset1");

        // PRESET rewrite during CNT only affects the next reload
        wr(32'h4, 32'd6);
        wr(32'h0, 32'hB);
        obs(6, 32'hB, 0, 3, "prewr");
        cyc(32'h4, 1'b1, 32'd2, 1'b1, 32'd6, 1'b1, 1'b0, "prewr_wr");
        obs(6, 32'hB, 4, 10, "prewr_old");
        obs(2, 32'hB, 2, 10, "prewr_new");
        stop_settle();

        // CTRL write on the INT cycle of a one-shot: bus wins, flag cleared, restart
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        obs(2, 32'h9, 0, 4, "coll");
        cyc(32'h0, 1'b1, 32'h9, 1'b1, 32'h9, 1'b1, 1'b1, "coll_wr");
        rd(32'h0, 32'h9, 1'b0, "coll_ctrl");
        obs(2, 32'h9, 1, 8, "coll_restart");
        stop_settle();

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            p     = int'($urandom_range(0, 9));
            ctrlv = {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            pe    = (p < 1) ? 1 : p;
            n     = 2 + 2 * (pe + 2) + int'($urandom_range(0, 3));
            run_timer(p, ctrlv, n, $sformatf("rnd%0d_p%0d_c%0h", r, p, ctrlv));
            stop_settle();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
